lsq_hash_scheduler: RTL and testbench
=====================================

// Module: lsq_hash_scheduler
// PURPOSE
//  Schedules the load/store unit's single memory port between incoming loads and a small in-order queue of
//  pending stores. Each store keeps its 4-bit address hash (addr[2..11] XOR-folded, addr_hash_t). A load whose
//  hash matches any queued store is held off. Committed stores drain in order; a starvation counter prevents
//  loads from blocking the store drain indefinitely.
// PARAMETERS
//  DEPTH          4   store queue entries; power of two, >=2
//  HASH_W         4   hash width; equals $bits(addr_hash_t)
//  STARVE_LIMIT   8   cycles an issuable head store may be denied before store priority; >=1
// PORTS
//  clk             in   1                    clock
//  rst             in   1                    synchronous reset, active-high
//  st_req_valid    in   1                    new store (program order) to enqueue
//  st_req_hash     in   HASH_W               hash of store address
//  st_req_ready    out  1                    queue can accept store
//  st_commit       in   1                    oldest uncommitted queued store is now committed
//  ld_req_valid    in   1                    load requesting the memory port
//  ld_req_hash     in   HASH_W               hash of load address
//  ld_req_ready    out  1                    load granted this cycle
//  ld_conflict     out  1                    ld_req_valid and hash matches a queued store
//  mem_ready       in   1                    memory port can accept one op this cycle
//  issue_ld        out  1                    load sent to port (ld_req_valid & ld_req_ready)
//  issue_st        out  1                    head store sent to port; dequeued same cycle
//  issue_st_idx    out  $clog2(DEPTH)        queue index of issuing store (data lookup)
//  sq_count        out  $clog2(DEPTH+1)      queued stores
//  store_prio      out  1                    arbiter in STORE_PRIO state
// BEHAVIOUR
//  Queue: circular buffer, head/tail/commit pointers wrap modulo DEPTH; entry = {valid, committed, hash}.
//  Enqueue when st_req_valid & st_req_ready; st_req_ready = !full & !rst (no dequeue lookahead when full).
//  st_commit marks the oldest uncommitted entry; it is ignored when all entries are committed or the queue
//    is empty (assertion flags it). A store enqueued and committed in the same cycle is not committed.
//  Conflict: ld_conflict = ld_req_valid & (ld_req_hash == hash of any valid entry, committed or not).
//    A same-cycle enqueued store is younger than the load and is not compared. Hash aliasing gives false
//    conflicts only (safe).
//  st_ok = head valid & head committed & mem_ready. ld_ok = ld_req_valid & !ld_conflict & mem_ready.
//  At most one of issue_ld/issue_st per cycle; both 0 when mem_ready=0.
//  FSM LOAD_PRIO (reset state):
//    ld_ok -> issue_ld; else st_ok -> issue_st.
//    Exception: queue full & st_ok -> issue_st.
//    starve_cnt increments each cycle st_ok & !issue_st, and clears on issue_st.
//    starve_cnt == STARVE_LIMIT-1 while incrementing -> STORE_PRIO.
//  FSM STORE_PRIO: st_ok -> issue_st; else ld_ok -> issue_ld.
//    On issue_st -> LOAD_PRIO, starve_cnt=0.
//  issue_st dequeues head the same cycle. Enqueue+dequeue in one cycle leaves sq_count unchanged.
//  Latency: a load with no conflict and mem_ready issues combinationally in its request cycle. A store
//    is issuable the cycle after both its enqueue and its commit have registered.
//  Reset (synchronous): all entries invalid, pointers=0, sq_count=0, starve_cnt=0, LOAD_PRIO.
//    issue_ld=issue_st=ld_req_ready=st_req_ready=0 while rst=1.
//    Reset mid-drain discards all queued stores, including committed ones (pipeline flush semantics
//    owned by caller).
//  ld_req_ready/issue_ld do not depend on st_req_valid (no comb loop via store path).
// TESTING
//  Reset, then 4 stores hashes 1,2,3,4, no commit -> sq_count=4, st_req_ready=0, 5th store held.
//  Queue {3,5} uncommitted. Load hash 5 -> ld_conflict=1, no issue. Load hash 6 -> issue_ld same cycle.
//  Commit both, mem_ready=1, continuous conflict-free loads, STARVE_LIMIT=8:
//    8 load issues -> store_prio=1 -> issue_st next cycle -> back to LOAD_PRIO.
//  Queue full, head committed, load valid, no conflict -> issue_st (full override); next cycle issue_ld.
//  mem_ready=0 for 5 cycles with committed store -> no issue, starve_cnt unchanged, sq_count steady.
//  Wrap: 10 enqueue/commit/drain cycles at DEPTH=4 -> issue_st_idx 0,1,2,3,0,...; sq_count never exceeds 4.
//  rst=1 with 3 queued stores in STORE_PRIO -> next cycle sq_count=0, LOAD_PRIO, no issue during rst.

Source files
------------

// File: rtl/lsq_hash_scheduler_if.sv
// Handshake bundle between the load/store pipeline and the memory-port scheduler.
interface lsq_hash_scheduler_if #(
  parameter int DEPTH  = 4,
  parameter int HASH_W = 4
);
  logic                       st_req_valid;
  logic [HASH_W-1:0]          st_req_hash;
  logic                       st_req_ready;
  logic                       st_commit;
  logic                       ld_req_valid;
  logic [HASH_W-1:0]          ld_req_hash;
  logic                       ld_req_ready;
  logic                       ld_conflict;
  logic                       mem_ready;
  logic                       issue_ld;
  logic                       issue_st;
  logic [$clog2(DEPTH)-1:0]   issue_st_idx;
  logic [$clog2(DEPTH+1)-1:0] sq_count;
  logic                       store_prio;

  modport master (
    output st_req_valid, st_req_hash, st_commit, ld_req_valid, ld_req_hash, mem_ready,
    input  st_req_ready, ld_req_ready, ld_conflict, issue_ld, issue_st, issue_st_idx,
           sq_count, store_prio
  );

  modport slave (
    input  st_req_valid, st_req_hash, st_commit, ld_req_valid, ld_req_hash, mem_ready,
    output st_req_ready, ld_req_ready, ld_conflict, issue_ld, issue_st, issue_st_idx,
           sq_count, store_prio
  );
endinterface

// File: rtl/lsq_hash_scheduler.sv
// Memory-port arbiter between loads and an in-order queue of hashed stores,
// with hash-based load hold-off and a starvation guard for the store drain.
//
// state      | meaning
// LOAD_PRIO  | loads win the port unless the queue is full
// STORE_PRIO | committed head store has starved; it wins the port next
module lsq_hash_scheduler #(
  parameter int DEPTH        = 4,
  parameter int HASH_W       = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  lsq_hash_scheduler_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef logic [HASH_W-1:0] addr_hash_t;
  typedef enum logic {LOAD_PRIO, STORE_PRIO} state_t;

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_committed;
  addr_hash_t       ent_hash [DEPTH];
  logic [PW-1:0]    head, tail, cmt;
  logic [CW-1:0]    count;
  logic [SW-1:0]    starve_cnt, starve_nxt;
  state_t           state, state_nxt;

  logic full, enq, cmt_avail, cmt_ok, hit, st_ok, ld_ok, pick_ld, pick_st;

  assign full      = (count == CW'(DEPTH));
  assign enq       = bus.st_req_valid && bus.st_req_ready;
  assign cmt_avail = ent_valid[cmt] && !ent_committed[cmt];
  assign cmt_ok    = bus.st_commit && cmt_avail;

  // Only registered entries are compared; a same-cycle enqueue is younger than the load.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_hash[i] == bus.ld_req_hash)) hit = 1'b1;
    end
  end

  assign st_ok = !rst && ent_valid[head] && ent_committed[head] && bus.mem_ready;
  assign ld_ok = !rst && bus.ld_req_valid && !bus.ld_conflict && bus.mem_ready;

  always_comb begin
    pick_ld    = 1'b0;
    pick_st    = 1'b0;
    state_nxt  = state;
    starve_nxt = starve_cnt;
    case (state)
      LOAD_PRIO: begin
        if (full && st_ok)  pick_st = 1'b1;
        else if (ld_ok)     pick_ld = 1'b1;
        else if (st_ok)     pick_st = 1'b1;
        if (st_ok && !pick_st) begin
          starve_nxt = starve_cnt + SW'(1);
          if (starve_cnt == SW'(STARVE_LIMIT - 1)) state_nxt = STORE_PRIO;
        end
      end
      STORE_PRIO: begin
        if (st_ok)      pick_st = 1'b1;
        else if (ld_ok) pick_ld = 1'b1;
      end
      default: state_nxt = LOAD_PRIO;
    endcase
    if (pick_st) begin
      starve_nxt = '0;
      state_nxt  = LOAD_PRIO;
    end
  end

  assign bus.st_req_ready = !full && !rst;
  assign bus.ld_conflict  = bus.ld_req_valid && hit;
  assign bus.ld_req_ready = pick_ld;
  assign bus.issue_ld     = bus.ld_req_valid && pick_ld;
  assign bus.issue_st     = pick_st;
  assign bus.issue_st_idx = head;
  assign bus.sq_count     = count;
  assign bus.store_prio   = (state == STORE_PRIO);

  // Commit, dequeue and enqueue never target the same slot in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid     <= '0;
      ent_committed <= '0;
      head          <= '0;
      tail          <= '0;
      cmt           <= '0;
      count         <= '0;
      starve_cnt    <= '0;
      state         <= LOAD_PRIO;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      if (cmt_ok) begin
        ent_committed[cmt] <= 1'b1;
        cmt                <= cmt + PW'(1);
      end
      if (pick_st) begin
        ent_valid[head]     <= 1'b0;
        ent_committed[head] <= 1'b0;
        head                <= head + PW'(1);
      end
      if (enq) begin
        ent_valid[tail]     <= 1'b1;
        ent_committed[tail] <= 1'b0;
        ent_hash[tail]      <= bus.st_req_hash;
        tail                <= tail + PW'(1);
      end
      count <= count + CW'(enq) - CW'(pick_st);
    end
  end

  a_commit_legal: assert property (@(posedge clk) disable iff (rst) bus.st_commit |-> cmt_avail);
endmodule

// File: tb/tb_lsq_hash_scheduler.sv
// Randomized and directed bench for lsq_hash_scheduler with a queue-based reference model.
module tb_lsq_hash_scheduler;
  localparam int DEPTH = 4;
  localparam int HW    = 4;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsq_hash_scheduler_if #(.DEPTH(DEPTH), .HASH_W(HW)) bus ();

  lsq_hash_scheduler #(.DEPTH(DEPTH), .HASH_W(HW), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct { logic [HW-1:0] h; bit c; } ent_t;
  typedef struct { bit st_rdy; bit ld_rdy; bit conf; bit ild; bit ist; int idx; int cnt; bit prio; } exp_t;

  ent_t mq[$];
  exp_t eq[$];
  bit   m_prio   = 0;
  int   m_starve = 0;
  int   m_head   = 0;
  int   checks   = 0;
  int   errors   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit has_uncommitted();
    foreach (mq[i]) if (!mq[i].c) return 1'b1;
    return 1'b0;
  endfunction

  // One clock of stimulus; the model predicts this cycle's outputs, then advances.
  task automatic cycle(input bit r, input bit sv, input logic [HW-1:0] sh, input bit cm,
                       input bit lv, input logic [HW-1:0] lh, input bit mr);
    exp_t e;
    bit full = 0, st_ok = 0, ld_ok = 0, pst = 0, pld = 0, done = 0;
    @(posedge clk);
    #1;
    rst = r;
    bus.st_req_valid = sv; bus.st_req_hash = sh; bus.st_commit = cm;
    bus.ld_req_valid = lv; bus.ld_req_hash = lh; bus.mem_ready = mr;
    e.cnt  = mq.size();
    e.prio = m_prio;
    e.conf = 0;
    foreach (mq[i]) if (lv && mq[i].h == lh) e.conf = 1;
    e.st_rdy = 0;
    if (!r) begin
      full     = (mq.size() == DEPTH);
      e.st_rdy = !full;
      st_ok    = (mq.size() > 0) && mq[0].c && mr;
      ld_ok    = lv && !e.conf && mr;
      if (m_prio)              begin pst = st_ok; pld = !st_ok && ld_ok; end
      else if (full && st_ok)  pst = 1;
      else                     begin pld = ld_ok; pst = !ld_ok && st_ok; end
    end
    e.ld_rdy = pld; e.ild = pld; e.ist = pst; e.idx = m_head;
    eq.push_back(e);
    if (r) begin
      mq.delete(); m_prio = 0; m_starve = 0; m_head = 0;
    end else begin
      if (!m_prio && st_ok && !pst) begin
        if (m_starve == LIMIT - 1) m_prio = 1;
        m_starve++;
      end
      if (pst) begin m_starve = 0; m_prio = 0; end
      if (cm) for (int i = 0; i < mq.size() && !done; i++)
        if (!mq[i].c) begin mq[i].c = 1; done = 1; end
      if (pst) begin void'(mq.pop_front()); m_head = (m_head + 1) % DEPTH; end
      if (sv && e.st_rdy) mq.push_back('{h: sh, c: 1'b0});
    end
  endtask

  task automatic idle(input bit mr);
    cycle(0, 0, 0, 0, 0, 0, mr);
  endtask

  // Scoreboard monitor: one expectation per driven cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (eq.size() > 0) begin
        e = eq.pop_front();
        chk("st_req_ready", bus.st_req_ready, e.st_rdy);
        chk("ld_req_ready", bus.ld_req_ready, e.ld_rdy);
        chk("ld_conflict",  bus.ld_conflict,  e.conf);
        chk("issue_ld",     bus.issue_ld,     e.ild);
        chk("issue_st",     bus.issue_st,     e.ist);
        chk("sq_count",     bus.sq_count,     e.cnt);
        chk("store_prio",   bus.store_prio,   e.prio);
        if (e.ist) chk("issue_st_idx", bus.issue_st_idx, e.idx);
      end
    end
  end

  initial begin
    bit r, sv, cm, lv, mr;
    bus.st_req_valid = 0; bus.st_req_hash = 0; bus.st_commit = 0;
    bus.ld_req_valid = 0; bus.ld_req_hash = 0; bus.mem_ready = 0;

    // Reset, fill with 1..4, fifth store held off
    cycle(1, 0, 0, 0, 0, 0, 1); cycle(1, 0, 0, 0, 0, 0, 1);
    idle(1); #3;
    chk("rst_sq_count", bus.sq_count, 0);
    chk("rst_store_prio", bus.store_prio, 0);
    chk("rst_st_ready", bus.st_req_ready, 1);
    for (int i = 1; i <= 4; i++) cycle(0, 1, 4'(i), 0, 0, 0, 1);
    cycle(0, 1, 5, 0, 0, 0, 1); #3;
    chk("full_count", bus.sq_count, 4);
    chk("full_st_ready", bus.st_req_ready, 0);
    idle(1); #3;
    chk("full_held", bus.sq_count, 4);

    // Conflict hold-off then a conflict-free load
    cycle(1, 0, 0, 0, 0, 0, 1);
    cycle(0, 1, 3, 0, 0, 0, 1); cycle(0, 1, 5, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1, 5, 1); #3;
    chk("conf_flag", bus.ld_conflict, 1);
    chk("conf_noissue", bus.issue_ld, 0);
    cycle(0, 0, 0, 0, 1, 6, 1); #3;
    chk("noconf_issue", bus.issue_ld, 1);

    // Starvation: 8 loads win, then the store takes the port
    cycle(0, 0, 0, 1, 0, 0, 0); cycle(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < LIMIT; i++) begin
      cycle(0, 0, 0, 0, 1, 7, 1); #3;
      chk("starve_ld", bus.issue_ld, 1);
    end
    cycle(0, 0, 0, 0, 1, 7, 1); #3;
    chk("prio_state", bus.store_prio, 1);
    chk("prio_issue_st", bus.issue_st, 1);
    chk("prio_no_ld", bus.issue_ld, 0);
    cycle(0, 0, 0, 0, 1, 7, 1); #3;
    chk("prio_back", bus.store_prio, 0);
    chk("prio_back_ld", bus.issue_ld, 1);

    // Full-queue override
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) cycle(0, 1, 4'(i), 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 9, 1); #3;
    chk("override_st", bus.issue_st, 1);
    chk("override_no_ld", bus.issue_ld, 0);
    cycle(0, 0, 0, 0, 1, 9, 1); #3;
    chk("override_next_ld", bus.issue_ld, 1);

    // Memory port stalled
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0, 0); cycle(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 0, 1, 9, 0); #3;
      chk("stall_no_issue", bus.issue_ld | bus.issue_st, 0);
      chk("stall_count", bus.sq_count, 1);
    end
    idle(1);

    // Pointer wrap
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 4'(i), 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 1); #3;
      chk("wrap_issue", bus.issue_st, 1);
      chk("wrap_idx", bus.issue_st_idx, i % DEPTH);
    end

    // Reset while in store priority
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) cycle(0, 1, 4'(i), 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < LIMIT; i++) cycle(0, 0, 0, 0, 1, 9, 1);
    cycle(1, 0, 0, 0, 1, 9, 1); #3;
    chk("rstp_prio_before", bus.store_prio, 1);
    chk("rstp_no_issue", bus.issue_ld | bus.issue_st, 0);
    chk("rstp_ld_ready", bus.ld_req_ready, 0);
    idle(1); #3;
    chk("rstp_count", bus.sq_count, 0);
    chk("rstp_prio_after", bus.store_prio, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 199) == 0);
      sv = $urandom_range(0, 1);
      cm = has_uncommitted() && ($urandom_range(0, 2) == 0);
      lv = ($urandom_range(0, 3) != 0);
      mr = ($urandom_range(0, 4) != 0);
      cycle(r, sv, 4'($urandom_range(0, 7)), cm, lv, 4'($urandom_range(0, 7)), mr);
    end
    idle(0);
    @(negedge clk); #1;
    chk("scoreboard_drained", eq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
